// File: rtl/lsu_mem_stage.sv
// Load/store unit for the EX->MEM path: alignment check, byte-lane steering, single-outstanding
// req/ack memory port and extended load writeback. Define LSU_TIMEOUT_EN to enable the wait timeout.
module lsu_mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    output logic        lsu_busy,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_fault
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        req_q, we_q, ld_q, wb_valid_q, fault_q;
    logic [31:0] addr_q, wdata_q, wb_data_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q, wb_rd_q;

    logic in_idle, in_wait, accept, f3_bad, misalign;
    logic accept_legal, accept_illegal, done_ack, timeout;

    function automatic logic [3:0] steer_wstrb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] steer_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] w);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        sh = w >> {lane, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  r = b;
            3'b001:  r = h;
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign in_idle  = (state_q == S_IDLE);
    assign in_wait  = (state_q == S_WAIT);
    assign accept   = in_idle & ex_valid & (ex_load ^ ex_store);
    assign f3_bad   = ex_load ? !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : !(ex_funct3 inside {3'b000, 3'b001, 3'b010});
    assign misalign = ((ex_funct3[1:0] == 2'b01) & alu_out[0]) |
                      ((ex_funct3[1:0] == 2'b10) & (alu_out[1:0] != 2'b00));
    assign accept_legal   = accept & ~f3_bad & ~misalign;
    assign accept_illegal = (accept & (f3_bad | misalign)) |
                            (in_idle & ex_valid & ex_load & ex_store);
    assign done_ack = in_wait & dm_ack;

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Timeout fires in the cycle whose missing ack brings the count to MAX_WAIT.
    assign timeout = in_wait & ~dm_ack & (sat_inc(cnt_q) >= 8'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (accept_legal)
            cnt_d = 8'd0;
        else if (in_wait & ~dm_ack)
            cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_legal) state_d = S_WAIT;
            S_WAIT:  if (dm_ack | timeout) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lsu_busy = accept_legal | (in_wait & ~dm_ack & ~timeout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            ld_q       <= 1'b0;
            f3_q       <= 3'd0;
            lane_q     <= 2'd0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            fault_q    <= accept_illegal | timeout;
            wb_valid_q <= done_ack & ld_q;
            if (done_ack & ld_q) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= load_extract(f3_q, lane_q, dm_rdata);
            end
            if (accept_legal) begin
                req_q   <= 1'b1;
                we_q    <= ex_store;
                addr_q  <= {alu_out[31:2], 2'b00};
                wstrb_q <= ex_store ? steer_wstrb(ex_funct3, alu_out[1:0]) : 4'd0;
                wdata_q <= ex_store ? steer_wdata(ex_funct3, ex_rs2) : 32'd0;
                ld_q    <= ex_load;
                f3_q    <= ex_funct3;
                lane_q  <= alu_out[1:0];
                rd_q    <= ex_rd;
            end else if (done_ack | timeout) begin
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                wstrb_q <= 4'd0;
            end
        end
    end

    assign dm_req    = req_q;
    assign dm_we     = we_q;
    assign dm_addr   = addr_q;
    assign dm_wstrb  = wstrb_q;
    assign dm_wdata  = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign lsu_fault = fault_q;

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit sitting directly downstream of the ALU in the EX→MEM path. It takes the ALU result as the effective address, performs alignment checking and byte-lane steering, and runs a single-outstanding request/acknowledge transaction on the data-memory port. It returns sign- or zero-extended load data to writeback. While a transaction is in flight it stalls the pipeline.

## Interface
Parameters:
- MAX_WAIT, 15: cycles `dm_req` may stay high without `dm_ack` before a timeout fault. Legal range 1–255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage presents an instruction this cycle
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store
- ex_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_out  in  32  effective address from the ALU
- ex_rs2  in  32  store data
- ex_rd  in  5  load destination register
- lsu_busy  out  1  stall request to upstream stages (combinational)
- dm_req  out  1  memory request (registered)
- dm_we  out  1  1 = write
- dm_addr  out  32  word address; `{alu_out[31:2],2'b00}`
- dm_wstrb  out  4  byte write enables; 0 for reads
- dm_wdata  out  32  lane-steered store data
- dm_ack  in  1  memory completion; `dm_rdata` is valid in the same cycle
- dm_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- lsu_fault  out  1  one-cycle pulse: misaligned, illegal, or timeout

## Operation
- FSM states: IDLE, WAIT.
- Accept condition: `accept = IDLE & ex_valid & (ex_load ^ ex_store)`. Accepted operands are latched.
- Illegal access, checked at accept:
  - `ex_load & ex_store` with `ex_valid` high.
  - Loads: funct3 ∉ {000,001,010,100,101}. Stores: funct3 ∉ {000,001,010}.
  - H/HU with `addr[0]=1`. W with `addr[1:0]≠0`.
  - Response: no memory request, stay in IDLE, `lsu_fault`=1 on the next cycle, no `wb_valid`.
- Legal accept: go to WAIT; `dm_req`=1 from the next cycle.
- In WAIT, `dm_req`, `dm_we`, `dm_addr`, `dm_wstrb`, and `dm_wdata` are held stable until the cycle that contains `dm_ack`.
- Store steering:
  - SB: byte replicated ×4; `dm_wstrb = 1<<addr[1:0]`.
  - SH: halfword replicated ×2; `dm_wstrb` = 0011 or 1100.
  - SW: `dm_wstrb` = 1111.
- Load extraction: select the lane using the latched `addr[1:0]`; sign-extend for B/H, zero-extend for BU/HU.
- On `dm_ack` in WAIT:
  - Return to IDLE.
  - Loads only: register `wb_valid`=1, `wb_rd`, `wb_data` for the next cycle.
- `dm_ack` outside WAIT is ignored.
- `lsu_busy = accept_legal | (WAIT & ~dm_ack & ~timeout)`.
  - Upstream holds `ex_*` while `lsu_busy` is high.
  - An illegal access does not stall.
  - A new instruction can be accepted in the cycle after the ack.

## Timing
- Reset (`rst` high at an edge): state IDLE and counter 0. `dm_req`, `dm_we`, `dm_wstrb`, `wb_valid`, `lsu_fault` = 0; `dm_addr`, `dm_wdata`, `wb_rd`, `wb_data` = 0.
- Reset mid-transaction drops `dm_req` on the next edge; a late `dm_ack` is ignored.
- Accept in cycle T:
  - `dm_req` is high from T+1.
  - Fastest ack is at T+1.
  - `wb_valid` is at T+2.
  - Load-to-use latency is 2 cycles minimum.
- `wb_valid` and `lsu_fault` are never high in the same cycle. Each is a single-cycle pulse.
- Wait counter:
  - Clears on accept.
  - Increments each WAIT cycle without `dm_ack`.
  - Saturates; it does not wrap.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - When the counter reaches MAX_WAIT with no ack, timeout asserts.
  - `dm_req` drops on the next edge.
  - `lsu_fault` pulses in that next cycle and the FSM returns to IDLE.
  - If `dm_ack` arrives in the same cycle as the timeout, the ack wins (normal completion).
- Undefined: no counter logic; WAIT holds indefinitely until `dm_ack`. `lsu_fault` reports misaligned and illegal accesses only.

## Test plan
- LB, `alu_out`=0x1003, `dm_rdata`=0x80FF_FF12, ack at T+1 → `dm_addr`=0x1000, `dm_wstrb`=0; at T+2 `wb_valid`=1, `wb_data`=0xFFFF_FF80.
- SH, `alu_out`=0x2002, `ex_rs2`=0x1234_ABCD, ack delayed 3 cycles:
  - `dm_wdata`=0xABCD_ABCD and `dm_wstrb`=1100, held stable for 3 cycles.
  - `lsu_busy` high during the wait and low in the ack cycle.
  - No `wb_valid`.
- LW, `alu_out`=0x3002 → no `dm_req`; `lsu_fault`=1 for exactly one cycle; `lsu_busy` stays 0.
- LHU, `alu_out`=0x4000, `dm_rdata`=0x0000_8001 → `wb_data`=0x0000_8001. Then an immediate SW accepted in the cycle after the ack → `dm_req` is back-to-back with only one idle cycle.
- With `LSU_TIMEOUT_EN` and MAX_WAIT=15, LW with no ack → `dm_req` deasserts after 15 cycles, `lsu_fault` pulses once, and the next LW completes normally.
- Assert `rst` during WAIT, then pulse `dm_ack` one cycle after → all outputs 0 and no `wb_valid`.
